// File: rtl/apb_slave_mux.sv
// -----------------------------------------------------------------------------
// apb_slave_mux
//
// APB completer-side sequencer that sits below the AHB-to-APB bridge. It turns
// the bridge's transfer request into APB setup/access phases, decodes the
// address into a one-hot peripheral select and returns the selected slave's
// response to the bridge. A wait-state watchdog and an unmapped-address
// response keep a hung or missing peripheral from stalling the bridge.
//
// Ports:
//   hclk, hreset         clock and asynchronous active-high reset
//   psel_en, paddr       transfer request and address from the bridge
//   pready_x, pslverr_x  completion / error back to the bridge
//   prdata_x             read data back to the bridge
//   psel, penable        APB select (one-hot) and enable toward the slaves
//   pready_s, pslverr_s  per-slave ready / error
//   prdata_s             per-slave read data, slave i at [i*DW +: DW]
//   clr_status           pulse that clears the sticky status flags
//   timeout_flag         sticky: watchdog abort happened
//   timeout_idx          slave index of the most recent watchdog abort
//   decerr_flag          sticky: unmapped-address access happened
// -----------------------------------------------------------------------------
module apb_slave_mux #(
  parameter int NUM_SLV        = 4,
  parameter int PADDR_WIDTH    = 16,
  parameter int APB_DATA_WIDTH = 32,
  parameter int SEL_BITS       = 3,
  parameter int TIMEOUT        = 16
) (
  input  logic                              hclk,
  input  logic                              hreset,
  input  logic                              psel_en,
  input  logic [PADDR_WIDTH-1:0]            paddr,
  output logic                              pready_x,
  output logic                              pslverr_x,
  output logic [APB_DATA_WIDTH-1:0]         prdata_x,
  output logic [NUM_SLV-1:0]                psel,
  output logic                              penable,
  input  logic [NUM_SLV-1:0]                pready_s,
  input  logic [NUM_SLV-1:0]                pslverr_s,
  input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] prdata_s,
  input  logic                              clr_status,
  output logic                              timeout_flag,
  output logic [SEL_BITS-1:0]               timeout_idx,
  output logic                              decerr_flag
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last wait count before the watchdog forces completion.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  // One extra bit so NUM_SLV == 2**SEL_BITS still compares correctly.
  localparam logic [SEL_BITS:0] SLV_LIMIT = (SEL_BITS + 1)'(NUM_SLV);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  logic [SEL_BITS-1:0]  r_idx;
  logic                 r_err_lat;
  logic [CNT_W-1:0]     r_wait_cnt;

  state_t               w_state_nxt;
  logic [SEL_BITS-1:0]  w_idx_nxt;
  logic                 w_err_lat_nxt;
  logic [CNT_W-1:0]     w_wait_cnt_nxt;
  logic                 w_set_tmo;
  logic                 w_set_dec;

  logic [SEL_BITS-1:0]       w_dec_idx;
  logic                      w_dec_err;
  logic [NUM_SLV-1:0]        w_dec_oh;
  logic [NUM_SLV-1:0]        w_sel_oh;
  logic                      w_sel_rdy;
  logic                      w_sel_err;
  logic [APB_DATA_WIDTH-1:0] w_sel_data;

  // Only the slave-index field of the address takes part in decoding.
  logic w_unused_addr;
  assign w_unused_addr = ^paddr[PADDR_WIDTH-SEL_BITS-1:0];

  assign w_dec_idx = paddr[PADDR_WIDTH-1 -: SEL_BITS];
  assign w_dec_err = ({1'b0, w_dec_idx} >= SLV_LIMIT);

  // Address decode for the setup phase and response mux for the latched slave.
  always_comb begin
    w_dec_oh   = '0;
    w_sel_oh   = '0;
    w_sel_rdy  = 1'b0;
    w_sel_err  = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      // An out-of-range index matches no slave, so the one-hot stays zero.
      if (w_dec_idx == SEL_BITS'(i)) begin
        w_dec_oh[i] = 1'b1;
      end else begin
        w_dec_oh[i] = 1'b0;
      end
      if (r_idx == SEL_BITS'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_sel_rdy   = pready_s[i];
        w_sel_err   = pslverr_s[i];
        w_sel_data  = prdata_s[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end else begin
        w_sel_oh[i] = 1'b0;
      end
    end
  end

  // Next-state and APB/bridge outputs of the transfer sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_err_lat_nxt  = r_err_lat;
    w_wait_cnt_nxt = r_wait_cnt;
    w_set_tmo      = 1'b0;
    w_set_dec      = 1'b0;
    psel           = '0;
    penable        = 1'b0;
    pready_x       = 1'b0;
    pslverr_x      = 1'b0;
    prdata_x       = '0;
    case (r_state)
      ST_IDLE: begin
        if (psel_en) begin
          // This cycle is the APB setup phase.
          psel           = w_dec_oh;
          w_idx_nxt      = w_dec_idx;
          w_err_lat_nxt  = w_dec_err;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_err_lat) begin
          // Unmapped address: answer with an error, never touch a slave.
          pready_x    = 1'b1;
          pslverr_x   = 1'b1;
          w_set_dec   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          psel     = w_sel_oh;
          penable  = 1'b1;
          prdata_x = w_sel_data;
          if (w_sel_rdy) begin
            // Slave ready wins over a watchdog expiry in the same cycle.
            pready_x    = 1'b1;
            pslverr_x   = w_sel_err;
            w_state_nxt = ST_DONE;
          end else if (r_wait_cnt == CNT_LAST) begin
            pready_x    = 1'b1;
            pslverr_x   = 1'b1;
            prdata_x    = '0;
            w_set_tmo   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        // Hold while the bridge still requests so a finished transfer is not reissued.
        if (psel_en) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_err_lat  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_err_lat  <= w_err_lat_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Sticky status; a new event beats a clear arriving in the same cycle.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      timeout_flag <= 1'b0;
      timeout_idx  <= '0;
      decerr_flag  <= 1'b0;
    end else begin
      if (w_set_tmo) begin
        timeout_flag <= 1'b1;
        timeout_idx  <= r_idx;
      end else if (clr_status) begin
        timeout_flag <= 1'b0;
      end else begin
        timeout_flag <= timeout_flag;
      end
      if (w_set_dec) begin
        decerr_flag <= 1'b1;
      end else if (clr_status) begin
        decerr_flag <= 1'b0;
      end else begin
        decerr_flag <= decerr_flag;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mux.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mux
//
// Directed bench for apb_slave_mux with NUM_SLV=4, TIMEOUT=4. Expected values
// are pushed to a scoreboard queue as each cycle's stimulus is driven and are
// popped and compared against the DUT outputs on the following falling edge.
// -----------------------------------------------------------------------------
module tb_apb_slave_mux;

  localparam int NUM_SLV = 4;
  localparam int PAW     = 16;
  localparam int DW      = 32;
  localparam int SB      = 3;
  localparam int TMO     = 4;

  logic              hclk;
  logic              hreset;
  logic              psel_en;
  logic [PAW-1:0]    paddr;
  logic              pready_x;
  logic              pslverr_x;
  logic [DW-1:0]     prdata_x;
  logic [NUM_SLV-1:0] psel;
  logic              penable;
  logic [NUM_SLV-1:0] pready_s;
  logic [NUM_SLV-1:0] pslverr_s;
  logic [NUM_SLV*DW-1:0] prdata_s;
  logic              clr_status;
  logic              timeout_flag;
  logic [SB-1:0]     timeout_idx;
  logic              decerr_flag;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  apb_slave_mux #(
    .NUM_SLV(NUM_SLV), .PADDR_WIDTH(PAW), .APB_DATA_WIDTH(DW),
    .SEL_BITS(SB), .TIMEOUT(TMO)
  ) dut (
    .hclk(hclk), .hreset(hreset), .psel_en(psel_en), .paddr(paddr),
    .pready_x(pready_x), .pslverr_x(pslverr_x), .prdata_x(prdata_x),
    .psel(psel), .penable(penable), .pready_s(pready_s),
    .pslverr_s(pslverr_s), .prdata_s(prdata_s), .clr_status(clr_status),
    .timeout_flag(timeout_flag), .timeout_idx(timeout_idx),
    .decerr_flag(decerr_flag)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed=%0h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed=%0h expected=%0h at t=%0t", e.tag, obs, e.val, $time);
      end
    end
  endtask

  task automatic exp_bus(input logic [3:0] ps, input logic pe, input logic rd,
                         input logic er, input logic [31:0] d);
    push("psel", 32'(ps));
    push("penable", 32'(pe));
    push("pready_x", 32'(rd));
    push("pslverr_x", 32'(er));
    push("prdata_x", d);
  endtask

  task automatic pop_bus();
    cmp(32'(psel));
    cmp(32'(penable));
    cmp(32'(pready_x));
    cmp(32'(pslverr_x));
    cmp(prdata_x);
  endtask

  task automatic exp_stat(input logic tf, input logic df);
    push("timeout_flag", 32'(tf));
    push("decerr_flag", 32'(df));
  endtask

  task automatic pop_stat();
    cmp(32'(timeout_flag));
    cmp(32'(decerr_flag));
  endtask

  task automatic slv(input int i, input logic r, input logic e, input logic [31:0] d);
    pready_s[i]            = r;
    pslverr_s[i]           = e;
    prdata_s[i*DW +: DW]   = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hreset     = 1'b1;
    psel_en    = 1'b0;
    paddr      = 16'h0000;
    pready_s   = 4'b0000;
    pslverr_s  = 4'b0000;
    prdata_s   = '0;
    clr_status = 1'b0;

    // Reset state
    exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_stat(1'b0, 1'b0);
    push("timeout_idx", 32'h0);
    @(negedge hclk);
    pop_bus(); pop_stat(); cmp(32'(timeout_idx));
    cyc();
    hreset = 1'b0;

    // 1: zero-wait read from slave 2, request held into DONE
    psel_en = 1'b1; paddr = 16'h4010; slv(2, 1'b1, 1'b0, 32'hCAFE0001);
    exp_bus(4'b0100, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();
    cyc();
    exp_bus(4'b0100, 1'b1, 1'b1, 1'b0, 32'hCAFE0001);
    @(negedge hclk); pop_bus();
    for (int k = 0; k < 2; k++) begin
      cyc();
      exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge hclk); pop_bus();
    end
    cyc();
    psel_en = 1'b0; slv(2, 1'b0, 1'b0, 32'h0);
    cyc();

    // 2: slave 1 with two wait states, completes with error
    psel_en = 1'b1; paddr = 16'h2000; slv(1, 1'b0, 1'b1, 32'h0);
    exp_bus(4'b0010, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();
    for (int k = 0; k < 2; k++) begin
      cyc();
      exp_bus(4'b0010, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge hclk); pop_bus();
    end
    cyc();
    slv(1, 1'b1, 1'b1, 32'h12345678);
    exp_bus(4'b0010, 1'b1, 1'b1, 1'b1, 32'h12345678);
    @(negedge hclk); pop_bus();
    cyc();
    psel_en = 1'b0; slv(1, 1'b0, 1'b0, 32'h0);
    exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_stat(1'b0, 1'b0);
    @(negedge hclk); pop_bus(); pop_stat();
    cyc();

    // 3: slave 3 never ready -> watchdog abort, then clear
    psel_en = 1'b1; paddr = 16'h6000; slv(3, 1'b0, 1'b0, 32'h0);
    exp_bus(4'b1000, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();
    for (int k = 0; k < 3; k++) begin
      cyc();
      exp_bus(4'b1000, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge hclk); pop_bus();
    end
    cyc();
    slv(3, 1'b0, 1'b0, 32'hDEADBEEF);
    exp_bus(4'b1000, 1'b1, 1'b1, 1'b1, 32'h0);
    exp_stat(1'b0, 1'b0);
    @(negedge hclk); pop_bus(); pop_stat();
    cyc();
    psel_en = 1'b0; slv(3, 1'b0, 1'b0, 32'h0);
    exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_stat(1'b1, 1'b0);
    push("timeout_idx", 32'h3);
    @(negedge hclk); pop_bus(); pop_stat(); cmp(32'(timeout_idx));
    cyc();
    clr_status = 1'b1;
    cyc();
    clr_status = 1'b0;

    // 4: unmapped index 5, all slaves ready but none may be selected
    psel_en = 1'b1; paddr = 16'hA000; pready_s = 4'hF; prdata_s = '1;
    exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_stat(1'b0, 1'b0);
    @(negedge hclk); pop_bus(); pop_stat();
    cyc();
    exp_bus(4'b0000, 1'b0, 1'b1, 1'b1, 32'h0);
    @(negedge hclk); pop_bus();
    cyc();
    psel_en = 1'b0; pready_s = 4'h0; prdata_s = '0;
    exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_stat(1'b0, 1'b1);
    @(negedge hclk); pop_bus(); pop_stat();
    cyc();

    // 5: slave 0 ready exactly in the last allowed ACCESS cycle
    psel_en = 1'b1; paddr = 16'h0000; slv(0, 1'b0, 1'b0, 32'h0);
    exp_bus(4'b0001, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();
    for (int k = 0; k < 3; k++) begin
      cyc();
      exp_bus(4'b0001, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge hclk); pop_bus();
    end
    cyc();
    slv(0, 1'b1, 1'b0, 32'h0BADF00D);
    exp_bus(4'b0001, 1'b1, 1'b1, 1'b0, 32'h0BADF00D);
    @(negedge hclk); pop_bus();
    cyc();
    psel_en = 1'b0; slv(0, 1'b0, 1'b0, 32'h0);
    exp_stat(1'b0, 1'b1);
    @(negedge hclk); pop_stat();
    cyc();
    // clear coinciding with a fresh decode error: set wins
    psel_en = 1'b1; paddr = 16'hE000;
    exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();
    cyc();
    clr_status = 1'b1;
    exp_bus(4'b0000, 1'b0, 1'b1, 1'b1, 32'h0);
    @(negedge hclk); pop_bus();
    cyc();
    clr_status = 1'b0; psel_en = 1'b0;
    exp_stat(1'b0, 1'b1);
    @(negedge hclk); pop_stat();
    cyc();

    // 6: timeout on slave 2 to load status, then reset mid-ACCESS
    psel_en = 1'b1; paddr = 16'h4000; slv(2, 1'b0, 1'b0, 32'h0);
    exp_bus(4'b0100, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();
    for (int k = 0; k < TMO; k++) begin
      cyc();
      exp_bus(4'b0100, 1'b1, (k == TMO-1), (k == TMO-1), 32'h0);
      @(negedge hclk); pop_bus();
    end
    cyc();
    psel_en = 1'b0;
    exp_stat(1'b1, 1'b1);
    push("timeout_idx", 32'h2);
    @(negedge hclk); pop_stat(); cmp(32'(timeout_idx));
    cyc();
    psel_en = 1'b1;
    exp_bus(4'b0100, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();
    for (int k = 0; k < 2; k++) begin
      cyc();
      exp_bus(4'b0100, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge hclk); pop_bus();
    end
    #1;
    hreset = 1'b1; psel_en = 1'b0;
    #1;
    exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_stat(1'b0, 1'b0);
    push("timeout_idx", 32'h0);
    pop_bus(); pop_stat(); cmp(32'(timeout_idx));
    cyc();
    hreset = 1'b0;
    psel_en = 1'b1; paddr = 16'h2000; slv(1, 1'b1, 1'b0, 32'h55AA55AA);
    exp_bus(4'b0010, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();
    cyc();
    exp_bus(4'b0010, 1'b1, 1'b1, 1'b0, 32'h55AA55AA);
    @(negedge hclk); pop_bus();
    cyc();
    psel_en = 1'b0;
    exp_bus(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge hclk); pop_bus();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mux.md
# apb_slave_mux

APB completer-side sequencer between the AHB-to-APB bridge and up to NUM_SLV APB peripherals.
- Decodes the bridge's paddr into a one-hot psel.
- Generates the APB setup/access phasing (penable) toward the peripherals.
- Multiplexes pready/pslverr/prdata back to the bridge as pready_x/pslverr_x/prdata_x.
- Protects the bridge from hung or unmapped peripherals with a wait-state watchdog and a decode-error response.
- Sits directly below the bridge's AHB slave interface FSM in the hclk domain.

## Interface
- NUM_SLV, 4: number of attached APB slaves (1..8).
- PADDR_WIDTH, 16: APB address width.
- APB_DATA_WIDTH, 32: APB data width.
- SEL_BITS, 3: slave-index field width, taken from paddr[PADDR_WIDTH-1 -: SEL_BITS].
- TIMEOUT, 16: maximum access-phase cycles before forced error (>=2).

Ports (clock and reset first):
- hclk  input  1  system clock; one clock, all logic on its rising edge.
- hreset  input  1  asynchronous, active-high reset.
- psel_en  input  1  transfer request from bridge; high from setup until completion.
- paddr  input  PADDR_WIDTH  transfer address from bridge.
- pready_x  output  1  completion to bridge.
- pslverr_x  output  1  error to bridge; valid only with pready_x.
- prdata_x  output  APB_DATA_WIDTH  read data to bridge.
- psel  output  NUM_SLV  one-hot slave select.
- penable  output  1  APB enable to all slaves.
- pready_s  input  NUM_SLV  per-slave ready.
- pslverr_s  input  NUM_SLV  per-slave error.
- prdata_s  input  NUM_SLV*APB_DATA_WIDTH  per-slave read data; slave i occupies bits [i*APB_DATA_WIDTH +: APB_DATA_WIDTH].
- clr_status  input  1  single-cycle pulse; clears sticky status.
- timeout_flag  output  1  sticky: a watchdog abort occurred.
- timeout_idx  output  SEL_BITS  index of the last aborted slave.
- decerr_flag  output  1  sticky: an unmapped-address access occurred.

## Operation
- dec_idx = paddr[PADDR_WIDTH-1 -: SEL_BITS]. dec_err = (dec_idx >= NUM_SLV).
- Registers:
  - state: IDLE, ACCESS, DONE.
  - idx: SEL_BITS wide.
  - err_lat: 1 bit.
  - wait_cnt: wide enough to hold TIMEOUT.
  - the three status outputs.
- IDLE:
  - With psel_en=1, the current cycle is the APB setup phase: psel[dec_idx]=1 (all-zero if dec_err) and penable=0.
  - At the edge: idx<=dec_idx, err_lat<=dec_err, wait_cnt<=0, state->ACCESS.
  - With psel_en=0, stay in IDLE.
- ACCESS, err_lat=1:
  - psel=0, penable=0.
  - pready_x=1, pslverr_x=1, prdata_x=0.
  - decerr_flag<=1; state->DONE.
- ACCESS, err_lat=0, while waiting:
  - psel[idx]=1, penable=1, prdata_x=prdata_s[idx].
  - pready_s[idx]=1: pready_x=1, pslverr_x=pslverr_s[idx], state->DONE.
  - pready_s[idx]=0 and wait_cnt<TIMEOUT-1: pready_x=0, wait_cnt++.
- ACCESS, err_lat=0, watchdog abort (pready_s[idx]=0 and wait_cnt==TIMEOUT-1):
  - pready_x=1, pslverr_x=1, prdata_x=0.
  - timeout_flag<=1, timeout_idx<=idx, state->DONE.
- DONE:
  - psel=0, penable=0, pready_x=0.
  - psel_en=0: state->IDLE. psel_en=1: hold in DONE, so a stale request is never re-issued.
- pready_x, pslverr_x, prdata_x, psel and penable are combinational from state/registers/inputs. Outside an ACCESS completion, pready_x=pslverr_x=0 and prdata_x=0.
- Status flags: set has priority over clr_status in the same cycle.

## Timing
- Reset (asynchronous, immediate) gives:
  - state=IDLE, idx=0, err_lat=0, wait_cnt=0.
  - timeout_flag=0, timeout_idx=0, decerr_flag=0.
  - pready_x=0, pslverr_x=0, prdata_x=0, penable=0.
  - psel=0 while psel_en=0.
- Zero-wait transfer:
  - Setup is 1 cycle (IDLE), access is 1 cycle (ACCESS) with pready_x=1 in that same cycle, then 1 DONE cycle.
  - The bridge's enable-phase sampling of pready_x occurs in the ACCESS cycle.
- Each slave wait state adds 1 ACCESS cycle. ACCESS never exceeds TIMEOUT cycles.
- Decode error: pready_x=1 in the first ACCESS cycle; no slave is ever selected.
- Slave ready and watchdog abort in the same cycle: normal completion wins; pslverr_x=pslverr_s[idx] and timeout_flag is unchanged.
- Back-to-back: when psel_en drops for 1 cycle after completion, DONE->IDLE. A new setup may begin the following cycle.
- paddr changes during ACCESS are ignored (idx is latched).
- Reset mid-ACCESS: the transfer is abandoned and all outputs return to reset values immediately.

## Test plan
NUM_SLV=4, TIMEOUT=4, PADDR_WIDTH=16, SEL_BITS=3.
1. psel_en=1 with paddr=0x4010, slave 2 pready_s[2]=1 and prdata_s[2]=0xCAFE0001:
   - setup cycle: psel=4'b0100, penable=0.
   - next cycle: penable=1, pready_x=1, pslverr_x=0, prdata_x=0xCAFE0001.
   - then DONE.
2. paddr=0x2000, slave 1 holds pready_s[1]=0 for 2 cycles then 1 with pslverr_s[1]=1:
   - 3 ACCESS cycles, pready_x high only in the third, pslverr_x=1.
   - timeout_flag stays 0.
3. paddr=0x6000, slave 3 never ready:
   - 4th ACCESS cycle: pready_x=1, pslverr_x=1.
   - next cycle: psel=0, timeout_flag=1, timeout_idx=3.
   - clr_status pulse clears timeout_flag.
4. paddr=0xA000 (idx 5): psel stays 0 throughout; first ACCESS cycle gives pready_x=1, pslverr_x=1; then decerr_flag=1.
5. Slave 0 asserts pready_s[0] exactly in the 4th ACCESS cycle: normal completion with pslverr_x=pslverr_s[0]=0 and timeout_flag=0. Then clr_status together with a new decode error leaves decerr_flag=1.
6. Assert hreset during ACCESS of a stalled transfer:
   - psel=0 (with psel_en low), penable=0 and pready_x=0 immediately.
   - All status flags and timeout_idx cleared.
   - After release, the next transfer completes normally.
